// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Shares the single RF write port between the in-order pipeline writeback
// and a queued multiply/divide unit (MDU) result stream. MDU results wait in
// a small circular FIFO and retire in idle writeback slots. A starvation
// counter forces a one-cycle pipeline stall when the head entry has waited
// too long. A pending-register mask is exported for decode hazard checks.
//
// Handshakes:
//   MDU side : a result transfers on any cycle where mdu_valid && mdu_ready.
//              mdu_ready is a function of registered occupancy only, so a
//              pop in the same cycle never raises it.
//   WB side  : a pipeline write is taken on any cycle where wb_valid &&
//              !stall_wb; while stall_wb is high the pipeline holds wb_*.
//
// Arbitration state is visible through grant_sel (combinational) and the
// registered buffer occupancy / starvation counter.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_index,
  input  logic [15:0]              wb_data,
  output logic                     stall_wb,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_index,
  input  logic [15:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     write_en_rf,
  output logic [4:0]               write_index_rf,
  output logic [15:0]              write_data_rf,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Grant decision encoding, in priority order FORCE > PIPE > DRAIN > IDLE.
  localparam logic [1:0] GRANT_IDLE  = 2'd0;
  localparam logic [1:0] GRANT_PIPE  = 2'd1;
  localparam logic [1:0] GRANT_DRAIN = 2'd2;
  localparam logic [1:0] GRANT_FORCE = 2'd3;

  logic [4:0]       slot_index [DEPTH];
  logic [15:0]      slot_data  [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic [1:0]       grant_sel;
  logic             head_valid;
  logic             push;
  logic             pop;

  assign head_valid = (count != '0);
  assign mdu_ready  = (count != FULL_COUNT);
  assign push       = mdu_valid && mdu_ready;
  assign pop        = (grant_sel == GRANT_FORCE) || (grant_sel == GRANT_DRAIN);
  assign stall_wb   = (grant_sel == GRANT_FORCE) && wb_valid;
  assign buf_count  = count;

  // Pick exactly one writer (or none) for this cycle.
  always_comb begin
    grant_sel = GRANT_IDLE;
    if (head_valid && (starve_cnt == STARVE_MAX)) begin
      grant_sel = GRANT_FORCE;
    end else if (wb_valid) begin
      grant_sel = GRANT_PIPE;
    end else if (head_valid) begin
      grant_sel = GRANT_DRAIN;
    end
  end

  // Circular MDU result buffer; push and pop never target the same slot
  // because a push needs a non-full buffer and a pop a non-empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_index[i] <= '0;
        slot_data[i]  <= '0;
      end
    end else begin
      if (pop) begin
        slot_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= rd_ptr + PW'(1);
      end
      if (push) begin
        slot_valid[wr_ptr] <= 1'b1;
        slot_index[wr_ptr] <= mdu_index;
        slot_data[wr_ptr]  <= mdu_data;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Count cycles the head entry waits without being granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (pop || !head_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Register the winner onto the RF write port; index/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_rf    <= 1'b0;
      write_index_rf <= '0;
      write_data_rf  <= '0;
    end else begin
      case (grant_sel)
        GRANT_PIPE: begin
          write_en_rf    <= 1'b1;
          write_index_rf <= wb_index;
          write_data_rf  <= wb_data;
        end
        GRANT_FORCE, GRANT_DRAIN: begin
          write_en_rf    <= 1'b1;
          write_index_rf <= slot_index[rd_ptr];
          write_data_rf  <= slot_data[rd_ptr];
        end
        default: begin
          write_en_rf <= 1'b0;
        end
      endcase
    end
  end

  // Destination registers of all buffered results; duplicates simply OR.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        pending_mask[slot_index[i]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wb_valid  = 1'b0;
  logic [4:0]  wb_index  = '0;
  logic [15:0] wb_data   = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_index = '0;
  logic [15:0] mdu_data  = '0;
  logic        stall_wb;
  logic        mdu_ready;
  logic        write_en_rf;
  logic [4:0]  write_index_rf;
  logic [15:0] write_data_rf;
  logic [31:0] pending_mask;
  logic [$clog2(DEPTH):0] buf_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .stall_wb(stall_wb),
    .mdu_valid(mdu_valid), .mdu_index(mdu_index), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .write_en_rf(write_en_rf), .write_index_rf(write_index_rf),
    .write_data_rf(write_data_rf),
    .pending_mask(pending_mask), .buf_count(buf_count)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];          // {index, data} of buffered MDU results
  int          starve_m   = 0;
  logic        exp_we     = 1'b0;
  logic [4:0]  exp_wi     = '0;
  logic [15:0] exp_wd     = '0;
  bit          last_stall = 1'b0; // pipeline must hold wb_* next cycle
  bit          mdu_hold   = 1'b0; // MDU must hold its result next cycle
  int          stuck_cycles = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] m_mask;
    int          sz;
    bit          head, frc, pop, acc;
    if (!rst_n) begin
      exp_q.delete();
      starve_m = 0;
      exp_we   = 1'b0;
      exp_wi   = '0;
      exp_wd   = '0;
    end
    sz   = exp_q.size();
    head = (sz > 0);
    frc  = head && (starve_m == STARVE_LIMIT);
    m_mask = '0;
    foreach (exp_q[i]) m_mask[exp_q[i][20:16]] = 1'b1;

    chk("write_en_rf",    32'(write_en_rf),    32'(exp_we));
    chk("write_index_rf", 32'(write_index_rf), 32'(exp_wi));
    chk("write_data_rf",  32'(write_data_rf),  32'(exp_wd));
    chk("stall_wb",       32'(stall_wb),       32'(frc && wb_valid));
    chk("mdu_ready",      32'(mdu_ready),      32'(sz != DEPTH));
    chk("pending_mask",   pending_mask,        m_mask);
    chk("buf_count",      32'(buf_count),      32'(sz));

    if (!rst_n) begin
      last_stall   = 1'b0;
      mdu_hold     = 1'b0;
      stuck_cycles = 0;
    end else begin
      pop = 1'b0;
      if (frc) begin
        exp_we = 1'b1; exp_wi = exp_q[0][20:16]; exp_wd = exp_q[0][15:0]; pop = 1'b1;
      end else if (wb_valid) begin
        exp_we = 1'b1; exp_wi = wb_index; exp_wd = wb_data;
      end else if (head) begin
        exp_we = 1'b1; exp_wi = exp_q[0][20:16]; exp_wd = exp_q[0][15:0]; pop = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      if (pop || !head) starve_m = 0;
      else if (starve_m < STARVE_LIMIT) starve_m++;
      acc = mdu_valid && (sz != DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({mdu_index, mdu_data});
      last_stall = frc && wb_valid;
      mdu_hold   = mdu_valid && !acc;
      if (mdu_valid && !mdu_ready) stuck_cycles++;
      else stuck_cycles = 0;
      if (stuck_cycles == 65) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mdu_stuck: mdu_valid held with mdu_ready=0 for %0d cycles, limit 64", stuck_cycles);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit wv, input logic [4:0] wi, input logic [15:0] wd,
                     input bit mv, input logic [4:0] mi, input logic [15:0] md);
    @(posedge clk); #1;
    wb_valid = wv; wb_index = wi; wb_data = wd;
    mdu_valid = mv; mdu_index = mi; mdu_data = md;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    probe();
    chk("reset_we",    32'(write_en_rf), 32'd0);
    chk("reset_ready", 32'(mdu_ready),   32'd1);
    chk("reset_count", 32'(buf_count),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain pipeline write: one-cycle latency to the RF port.
    cyc(1, 5'd3, 16'h1234, 0, 5'd0, 16'h0);
    probe();
    chk("t1_stall", 32'(stall_wb), 32'd0);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t1_we",   32'(write_en_rf),    32'd1);
    chk("t1_idx",  32'(write_index_rf), 32'd3);
    chk("t1_data", 32'(write_data_rf),  32'h1234);

    // MDU push in an idle slot: drained next cycle, written the one after.
    cyc(0, 5'd0, 16'h0, 1, 5'd7, 16'hBEEF);
    probe();
    chk("t2_mask_push", pending_mask, 32'h0);
    chk("t2_we_push",   32'(write_en_rf), 32'd0);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t2_mask_grant", pending_mask, 32'h80);
    chk("t2_count",      32'(buf_count), 32'd1);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t2_idx",   32'(write_index_rf), 32'd7);
    chk("t2_data",  32'(write_data_rf),  32'hBEEF);
    chk("t2_clear", pending_mask,        32'h0);

    // Starvation: continuous pipeline traffic forces a one-cycle stall.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (!last_stall) begin
        wb_valid = 1'b1; wb_index = 5'd4; wb_data = 16'h2000 + 16'(k);
      end
      mdu_valid = (k == 0); mdu_index = 5'd9; mdu_data = 16'h9999;
      probe();
      if (k == 4) chk("t3_no_stall_yet", 32'(stall_wb), 32'd0);
      if (k == 5) chk("t3_stall", 32'(stall_wb), 32'd1);
      if (k == 6) begin
        chk("t3_stall_drop",  32'(stall_wb),       32'd0);
        chk("t3_force_idx",   32'(write_index_rf), 32'd9);
        chk("t3_force_data",  32'(write_data_rf),  32'h9999);
      end
      if (k == 7) begin
        chk("t3_resume_idx",  32'(write_index_rf), 32'd4);
        chk("t3_resume_data", 32'(write_data_rf),  32'h2005);
      end
    end

    // Full buffer: push rejected while full, accepted next cycle, order kept.
    cyc(1, 5'd10, 16'h00A0, 1, 5'd1, 16'h0101);
    probe(); chk("t4_count_a", 32'(buf_count), 32'd0);
    cyc(1, 5'd10, 16'h00A1, 1, 5'd2, 16'h0202);
    probe(); chk("t4_count_b", 32'(buf_count), 32'd1);
    cyc(0, 5'd0, 16'h0, 1, 5'd3, 16'h0303);
    probe();
    chk("t4_full_ready", 32'(mdu_ready), 32'd0);
    chk("t4_count_c",    32'(buf_count), 32'd2);
    cyc(1, 5'd10, 16'h00A3, 1, 5'd3, 16'h0303);
    probe();
    chk("t4_count_d", 32'(buf_count),      32'd1);
    chk("t4_ready_d", 32'(mdu_ready),      32'd1);
    chk("t4_first",   32'(write_index_rf), 32'd1);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe(); chk("t4_count_e", 32'(buf_count), 32'd2);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t4_count_f", 32'(buf_count),      32'd1);
    chk("t4_second",  32'(write_index_rf), 32'd2);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t4_count_g", 32'(buf_count),      32'd0);
    chk("t4_third",   32'(write_index_rf), 32'd3);
    chk("t4_third_d", 32'(write_data_rf),  32'h0303);

    // Mid-cycle reset discards queued results.
    cyc(1, 5'd6, 16'h00C0, 1, 5'd11, 16'h0B0B);
    cyc(1, 5'd6, 16'h00C1, 1, 5'd12, 16'h0C0C);
    cyc(1, 5'd6, 16'h00C2, 0, 5'd0, 16'h0);
    probe();
    chk("t5_count_before", 32'(buf_count), 32'd2);
    #2;
    rst_n = 1'b0;
    wb_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    chk("t5_we",    32'(write_en_rf),    32'd0);
    chk("t5_idx",   32'(write_index_rf), 32'd0);
    chk("t5_data",  32'(write_data_rf),  32'd0);
    chk("t5_mask",  pending_mask,        32'd0);
    chk("t5_count", 32'(buf_count),      32'd0);
    chk("t5_ready", 32'(mdu_ready),      32'd1);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
      probe();
      chk("t5_no_write", 32'(write_en_rf), 32'd0);
    end

    // Duplicate destinations keep the pending bit until the last pop.
    cyc(1, 5'd8, 16'h00D0, 1, 5'd5, 16'h5A5A);
    cyc(1, 5'd8, 16'h00D1, 1, 5'd5, 16'h5B5B);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe(); chk("t6_mask_two", pending_mask, 32'h20);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t6_mask_one", pending_mask,        32'h20);
    chk("t6_first",    32'(write_data_rf),  32'h5A5A);
    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    probe();
    chk("t6_mask_none", pending_mask,       32'h0);
    chk("t6_second",    32'(write_data_rf), 32'h5B5B);
    chk("t6_second_i",  32'(write_index_rf), 32'd5);

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == 1501) rst_n = 1'b1;
      if (!last_stall) begin
        wb_valid = ($urandom_range(0, 99) < 75);
        wb_index = 5'($urandom_range(0, 31));
        wb_data  = 16'($urandom);
      end
      if (!mdu_hold) begin
        mdu_valid = ($urandom_range(0, 99) < 40);
        mdu_index = 5'($urandom_range(0, 7));
        mdu_data  = 16'($urandom);
      end
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        wb_valid = 1'b0; mdu_valid = 1'b0;
      end
    end

    cyc(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    repeat (6) @(posedge clk);
    probe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
